apb_simple_requester: RTL and testbench

APB_SIMPLE_REQUESTER -- requirements
Module: apb_simple_requester

---
 rtl/apb_simple_requester_if.sv | 26 ++
 rtl/apb_simple_requester.sv | 123 ++++++++++++
 tb/tb_apb_simple_requester.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_simple_requester_if.sv
// APB bus bundle between one requester and one completer.
interface apb_simple_requester_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport requester (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport completer (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_simple_requester.sv
// Single-outstanding APB requester: turns one request strobe into a SETUP/ACCESS
// transfer and reports completion, completer error or timeout.
module apb_simple_requester #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_en,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  apb_simple_requester_if.requester apb
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  if ($bits(apb.pwdata) != 16) begin : g_bad_data_width
    $error("apb_simple_requester: APB data width must be 16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("apb_simple_requester: TIMEOUT must be within 1..65535");
  end

  logic [1:0]            state;
  logic [CW-1:0]         wait_cnt;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [15:0]           pwdata_q;
  logic                  rsp_valid_q;
  logic [15:0]           rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  // wait_cnt holds the number of ACCESS cycles already spent without pready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_en) begin
            state     <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= req_write;
            paddr_q   <= req_addr;
            pwdata_q  <= req_wdata;
            wait_cnt  <= '0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (apb.pready) begin
            state         <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? 16'h0000 : apb.prdata;
            rsp_err_q     <= apb.pslverr;
            rsp_timeout_q <= 1'b0;
          end else if (wait_cnt == LAST_WAIT) begin
            state         <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= 16'h0000;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = '1;
  assign apb.pprot   = 3'b000;

endmodule

// File: tb/tb_apb_simple_requester.sv
// Bench for apb_simple_requester: configurable completer, transaction-age reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_apb_simple_requester;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_en = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  int   wait_states = 0;
  logic never_ready = 1'b0;
  logic err_writes  = 1'b0;
  logic err_rand    = 1'b0;
  int   wcnt = 0;

  int n_checks = 0;
  int n_fails  = 0;

  apb_simple_requester_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) apb ();

  apb_simple_requester #(.ADDR_WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .apb(apb)
  );

  always #5 clk = ~clk;

  // Completer: answers after wait_states extra ACCESS cycles, read data derived from address.
  assign apb.pready  = apb.psel && apb.penable && !never_ready && (wcnt >= wait_states);
  assign apb.prdata  = apb.paddr ^ 16'h1224;
  assign apb.pslverr = apb.pready && ((err_writes && apb.pwrite) || err_rand);

  always @(posedge clk) begin
    if (rst || !(apb.psel && apb.penable) || apb.pready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Reference model: m_age counts cycles since a request was accepted (0 = idle,
  // 1 = setup, k+1 = k-th access cycle).
  int          m_age = 0;
  logic        m_init = 1'b0;
  logic        m_write = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic        m_valid = 1'b0;
  logic [15:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        m_to = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_age <= 0; m_valid <= 1'b0; m_rdata <= '0; m_err <= 1'b0; m_to <= 1'b0;
      m_init <= 1'b1;
    end else begin
      m_valid <= 1'b0;
      if (m_age == 0) begin
        if (req_en) begin
          m_age <= 1; m_addr <= req_addr; m_write <= req_write; m_wdata <= req_wdata;
        end
      end else if (m_age >= 2 && apb.pready) begin
        m_age <= 0; m_valid <= 1'b1; m_err <= apb.pslverr; m_to <= 1'b0;
        m_rdata <= m_write ? 16'h0000 : apb.prdata;
      end else if (m_age - 1 == TIMEOUT) begin
        m_age <= 0; m_valid <= 1'b1; m_rdata <= 16'h0000; m_err <= 1'b1; m_to <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      checkOutput("req_ready",   32'(req_ready),   32'(m_age == 0));
      checkOutput("psel",        32'(apb.psel),    32'(m_age > 0));
      checkOutput("penable",     32'(apb.penable), 32'(m_age >= 2));
      checkOutput("rsp_valid",   32'(rsp_valid),   32'(m_valid));
      checkOutput("rsp_rdata",   32'(rsp_rdata),   32'(m_rdata));
      checkOutput("rsp_err",     32'(rsp_err),     32'(m_err));
      checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
      checkOutput("pstrb",       32'(apb.pstrb),   32'h3);
      checkOutput("pprot",       32'(apb.pprot),   32'h0);
      if (m_age > 0) begin
        checkOutput("paddr",  32'(apb.paddr),  32'(m_addr));
        checkOutput("pwrite", 32'(apb.pwrite), 32'(m_write));
        checkOutput("pwdata", 32'(apb.pwdata), 32'(m_wdata));
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    req_en = en; req_write = w; req_addr = a; req_wdata = d;
  endtask

  // One request strobe for one cycle, then wait (bounded) for its response.
  task automatic runTxn(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output int acc);
    lat = 0; acc = 0;
    @(negedge clk);
    applyStimulus(1'b1, w, a, d);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) req_en = 1'b0;
      if (apb.psel && apb.penable) acc++;
      if (rsp_valid) begin lat = i; break; end
    end
    if (lat == 0) checkOutput("rsp_wait_bound", 32'd0, 32'd1);
  endtask

  int lat, acc, rsp_cnt;

  initial begin
    $display("[TB] start");
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_psel",      32'(apb.psel), 32'd0);
    checkOutput("rst_penable",   32'(apb.penable), 32'd0);
    checkOutput("rst_paddr",     32'(apb.paddr), 32'd0);
    checkOutput("rst_pwdata",    32'(apb.pwdata), 32'd0);
    checkOutput("rst_pwrite",    32'(apb.pwrite), 32'd0);
    checkOutput("rst_rsp",       32'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 32'd0);
    rst = 1'b0;

    // Zero-wait read of the status register.
    runTxn(1'b0, 16'h0010, 16'h0000, lat, acc);
    checkOutput("read_latency", 32'(lat), 32'd3);
    checkOutput("read_access_cycles", 32'(acc), 32'd1);
    checkOutput("read_rdata", 32'(rsp_rdata), 32'h1234);
    checkOutput("read_err_to", 32'({rsp_err, rsp_timeout}), 32'd0);

    // Write rejected by the completer.
    err_writes = 1'b1;
    runTxn(1'b1, 16'h0020, 16'hBEEF, lat, acc);
    checkOutput("werr_flags", 32'({rsp_err, rsp_timeout}), 32'b10);
    checkOutput("werr_rdata", 32'(rsp_rdata), 32'd0);
    err_writes = 1'b0;

    // Completer never answers.
    never_ready = 1'b1;
    runTxn(1'b0, 16'h0030, 16'h0000, lat, acc);
    checkOutput("to_access_cycles", 32'(acc), 32'd8);
    checkOutput("to_latency", 32'(lat), 32'd10);
    checkOutput("to_flags", 32'({rsp_err, rsp_timeout}), 32'b11);
    checkOutput("to_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("to_psel", 32'(apb.psel), 32'd0);
    never_ready = 1'b0;

    // Three wait states; a second request is held into the response cycle.
    wait_states = 3;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) applyStimulus(1'b1, 1'b1, 16'h0200, 16'h5A5A);
      if (rsp_valid) begin lat = i; break; end
    end
    checkOutput("ws3_latency", 32'(lat), 32'd6);
    checkOutput("ws3_rdata", 32'(rsp_rdata), 32'(16'h0100 ^ 16'h1224));
    @(negedge clk);
    req_en = 1'b0;
    checkOutput("b2b_setup", 32'({apb.psel, apb.penable}), 32'b10);
    checkOutput("b2b_paddr", 32'(apb.paddr), 32'h0200);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    checkOutput("b2b_done", 32'(rsp_valid), 32'd1);

    // Reset pulse in the second ACCESS cycle aborts the transfer.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0000);
    @(negedge clk); req_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_in_access", 32'({apb.psel, apb.penable}), 32'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_psel", 32'(apb.psel), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    rsp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) rsp_cnt++;
      @(negedge clk);
    end
    checkOutput("abort_no_rsp", 32'(rsp_cnt), 32'd0);
    wait_states = 0;
    runTxn(1'b0, 16'h0042, 16'h0000, lat, acc);
    checkOutput("after_abort_latency", 32'(lat), 32'd3);
    checkOutput("after_abort_rdata", 32'(rsp_rdata), 32'h1266);

    // Requests toggled during SETUP and ACCESS must be ignored.
    wait_states = 2;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0400, 16'h0000);
    rsp_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i <= 4) applyStimulus(i[0], 1'b1, 16'($urandom), 16'($urandom));
      else req_en = 1'b0;
      if (i == 3) checkOutput("ignore_paddr", 32'(apb.paddr), 32'h0400);
      if (rsp_valid) rsp_cnt++;
    end
    checkOutput("ignore_one_rsp", 32'(rsp_cnt), 32'd1);

    // Randomised traffic, completer behaviour and occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (req_ready) begin
        wait_states = $urandom_range(0, 3);
        never_ready = ($urandom_range(0, 9) == 0);
        err_writes  = 1'($urandom_range(0, 1));
      end
      err_rand = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 79) == 0);
      applyStimulus($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                    16'($urandom), 16'($urandom));
    end
    @(negedge clk);
    rst = 1'b0;
    req_en = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
